// File: rtl/serial_paralelo_if.sv
// Byte-deserializer bus: serial bit in, deserialized byte and link status out.
// slave is the deserializer side; master is the upstream driver / downstream consumer.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
  logic       los;

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active,
    output los
  );

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active,
    input  los
  );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver. Hunts for the IDLE (COM) symbol to find byte alignment,
// declares the link active after BC_COUNT aligned idles and then presents one byte per
// 8 bit clocks. Idle bytes in the active state are presented with valid_out low.
// Optional feature: define SP_LOS_EN to drop sync after STUCK_LIMIT consecutive
// 0x00/0xFF bytes (one-cycle los pulse). Without it, los is tied low.
module serial_paralelo #(
  parameter logic [7:0]  IDLE        = 8'hBC,
  parameter int unsigned BC_COUNT    = 4,
  parameter int unsigned STUCK_LIMIT = 8
) (
  input  logic               clk_32f,
  input  logic               reset,
  serial_paralelo_if.slave   bus
);

  typedef enum logic [1:0] {StSearch, StAlign, StActive} state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;
  logic       los_q, los_d;

  logic [7:0] win;
  logic [3:0] bc_inc;
  logic       boundary;
  logic       win_idle;
  logic       present;

`ifdef SP_LOS_EN
  localparam int unsigned StuckW = $clog2(STUCK_LIMIT + 1);
  logic [StuckW-1:0] stuck_q, stuck_d;
  logic              win_stuck;
`else
  logic unused_stuck_limit;
  assign unused_stuck_limit = ^STUCK_LIMIT;
`endif

  // Next-state: alignment FSM, byte framing and output updates.
  always_comb begin
    win       = {shift_q[6:0], bus.data_in};
    boundary  = (bit_cnt_q == 3'd7);
    win_idle  = (win == IDLE);
    bc_inc    = bc_cnt_q + 4'd1;
    present   = 1'b0;

    shift_d   = win;
    bit_cnt_d = bit_cnt_q + 3'd1;
    state_d   = state_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;
    los_d     = 1'b0;
`ifdef SP_LOS_EN
    win_stuck = (win == 8'h00) || (win == 8'hFF);
    stuck_d   = stuck_q;
`endif

    unique case (state_q)
      StSearch: begin
        if (win_idle) begin
          // Zero here puts the next wrap exactly 8 edges out.
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = StAlign;
        end
      end
      StAlign: begin
        if (boundary) begin
          if (win_idle) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == 4'(BC_COUNT)) begin
              state_d  = StActive;
              active_d = 1'b1;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = StSearch;
          end
        end
      end
      StActive: begin
        if (boundary) begin
`ifdef SP_LOS_EN
          if (win_stuck) begin
            if (stuck_q == StuckW'(STUCK_LIMIT - 1)) begin
              // Sync lost: data_out keeps the last presented byte.
              state_d  = StSearch;
              active_d = 1'b0;
              valid_d  = 1'b0;
              los_d    = 1'b1;
              bc_cnt_d = 4'd0;
              stuck_d  = '0;
            end else begin
              stuck_d = stuck_q + StuckW'(1);
              present = 1'b1;
            end
          end else begin
            stuck_d = '0;
            present = 1'b1;
          end
`else
          present = 1'b1;
`endif
        end
      end
      default: state_d = StSearch;
    endcase

    if (present) begin
      data_d   = win;
      valid_d  = !win_idle;
      strobe_d = 1'b1;
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= StSearch;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
      los_q     <= 1'b0;
`ifdef SP_LOS_EN
      stuck_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
      los_q     <= los_d;
`ifdef SP_LOS_EN
      stuck_q   <= stuck_d;
`endif
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.byte_strobe = strobe_q;
  assign bus.active      = active_q;
`ifdef SP_LOS_EN
  assign bus.los         = los_q;
`else
  assign bus.los         = 1'b0;
  logic unused_los_q;
  assign unused_los_q = los_q;
`endif

endmodule
